// File: rtl/tick_event_counter.sv
// Synchronizes a divided clock into the clock_in domain, turns each rising edge into a tick,
// and counts those ticks (wrapping at MAX_COUNT) under a start/stop/clear FSM.
module tick_event_counter #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_COUNT = 59
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             clock_div,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             tick_out,
  output logic             overflow
);

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StRun    = 2'b01,
    StPaused = 2'b10
  } state_e;

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX_COUNT);

  state_e           state_q, state_d;
  logic             sync1_q, sync2_q, prev_q;
  logic             tick, counted;
  logic [WIDTH-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             tick_out_q, running_q;

  // prev follows sync2 in every state, so a rising edge seen while idle is simply lost.
  assign tick    = sync2_q & ~prev_q;
  assign counted = tick & (state_q == StRun) & ~clear & ~stop;

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = StIdle;
    end else if (stop) begin
      if (state_q == StRun) state_d = StPaused;
    end else if (start) begin
      unique case (state_q)
        StIdle, StPaused: state_d = StRun;
        default:          state_d = state_q;
      endcase
    end
  end

  always_comb begin
    count_d    = count_q;
    overflow_d = overflow_q;
    if (clear) begin
      count_d    = '0;
      overflow_d = 1'b0;
    end else if (counted) begin
      if (count_q == MaxVal) begin
        count_d    = '0;
        overflow_d = 1'b1;
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      prev_q     <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      tick_out_q <= 1'b0;
      running_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= clock_div;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      tick_out_q <= counted;
      running_q  <= (state_d == StRun);
    end
  end

  assign count    = count_q;
  assign running  = running_q;
  assign tick_out = tick_out_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_tick_event_counter.sv
// Directed scenarios plus randomized clock_div/control traffic, all checked every cycle
// against a sample-history reference model of the tick counter.
module tb_tick_event_counter;

  localparam int W    = 8;
  localparam int MAXC = 59;

  logic         clock_in  = 1'b0;
  logic         reset_n   = 1'b0;
  logic         clock_div = 1'b0;
  logic         start     = 1'b0;
  logic         stop      = 1'b0;
  logic         clear     = 1'b0;
  logic [W-1:0] count;
  logic         running, tick_out, overflow;

  int checks = 0;
  int errors = 0;
  int tick_cnt = 0;

  always #5 clock_in = ~clock_in;

  tick_event_counter #(
    .WIDTH    (W),
    .MAX_COUNT(MAXC)
  ) dut (
    .clock_in (clock_in),
    .reset_n  (reset_n),
    .clock_div(clock_div),
    .start    (start),
    .stop     (stop),
    .clear    (clear),
    .count    (count),
    .running  (running),
    .tick_out (tick_out),
    .overflow (overflow)
  );

  // Reference model: smp[k] is the clock_div value sampled k+1 edges ago (zero after reset).
  typedef enum int {MIdle, MRun, MPaused} mstate_e;
  mstate_e m_state = MIdle;
  int      m_count = 0;
  bit      m_ovf = 1'b0, m_tick_out = 1'b0, m_run = 1'b0;
  bit      smp0 = 1'b0, smp1 = 1'b0, smp2 = 1'b0;
  bit      m_tk, m_counted;
  bit      chk_en = 1'b0;

  always @(posedge clock_in) begin
    if (!reset_n) begin
      m_state = MIdle; m_count = 0; m_ovf = 0; m_tick_out = 0;
      smp0 = 0; smp1 = 0; smp2 = 0;
    end else begin
      m_tk       = smp1 && !smp2;
      m_counted  = m_tk && (m_state == MRun) && !clear && !stop;
      m_tick_out = m_counted;
      if (clear) begin
        m_count = 0; m_ovf = 0;
      end else if (m_counted) begin
        if (m_count == MAXC) begin m_count = 0; m_ovf = 1; end
        else m_count = m_count + 1;
      end
      if (clear) m_state = MIdle;
      else if (stop) begin if (m_state == MRun) m_state = MPaused; end
      else if (start && m_state != MRun) m_state = MRun;
      smp2 = smp1; smp1 = smp0; smp0 = clock_div;
    end
    m_run  = (m_state == MRun);
    chk_en = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock_in) begin
    if (chk_en) begin
      check("model_count", 32'(count), 32'(m_count));
      check("model_running", 32'(running), 32'(m_run));
      check("model_tick_out", 32'(tick_out), 32'(m_tick_out));
      check("model_overflow", 32'(overflow), 32'(m_ovf));
    end
    if (tick_out === 1'b1) tick_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock_in);
  endtask

  task automatic div_pulse(input int hi, input int lo);
    clock_div = 1'b1; cyc(hi);
    clock_div = 1'b0; cyc(lo);
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) div_pulse(5, 5);
  endtask

  task automatic do_start(); start = 1'b1; cyc(1); start = 1'b0; endtask
  task automatic do_stop();  stop  = 1'b1; cyc(1); stop  = 1'b0; endtask
  task automatic do_clear(); clear = 1'b1; cyc(1); clear = 1'b0; endtask

  int lat;
  int ph_left;

  initial begin
    // Reset held with start asserted.
    reset_n = 1'b0; start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      check("rst_count", 32'(count), 0);
      check("rst_running", 32'(running), 0);
      check("rst_overflow", 32'(overflow), 0);
      check("rst_tick_out", 32'(tick_out), 0);
    end
    start = 1'b0; reset_n = 1'b1; cyc(2);

    // Count and latency.
    do_start();
    check("run_after_start", 32'(running), 1);
    tick_cnt = 0;
    clock_div = 1'b1;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      cyc(1);
      if (tick_out === 1'b1) begin lat = k; break; end
    end
    check("latency_edges", 32'(lat), 3);
    cyc(2); clock_div = 1'b0; cyc(5);
    pulses(4);
    check("count_5", 32'(count), 5);
    check("tick_out_pulses_5", 32'(tick_cnt), 5);

    // Wrap at MAX_COUNT.
    do_clear(); do_start();
    pulses(59);
    check("wrap_pre_count", 32'(count), 59);
    check("wrap_pre_ovf", 32'(overflow), 0);
    pulses(1);
    check("wrap_count", 32'(count), 0);
    check("wrap_ovf", 32'(overflow), 1);
    pulses(3);
    check("wrap_after_count", 32'(count), 3);
    check("wrap_after_ovf", 32'(overflow), 1);

    // Pause holds count and suppresses tick_out.
    do_clear();
    check("clear_ovf", 32'(overflow), 0);
    do_start(); pulses(7);
    check("pause_pre", 32'(count), 7);
    do_stop(); tick_cnt = 0;
    pulses(4);
    check("pause_hold", 32'(count), 7);
    check("pause_no_tick", 32'(tick_cnt), 0);
    check("pause_running", 32'(running), 0);
    do_start(); pulses(2);
    check("resume_count", 32'(count), 9);

    // Clear coincident with a tick.
    clock_div = 1'b1; cyc(2);
    clear = 1'b1; cyc(1); clear = 1'b0;
    check("clr_tick_count", 32'(count), 0);
    check("clr_tick_running", 32'(running), 0);
    check("clr_tick_tick_out", 32'(tick_out), 0);
    cyc(3); clock_div = 1'b0; cyc(5);
    do_start();
    start = 1'b1; stop = 1'b1; clear = 1'b1; cyc(1);
    start = 1'b0; stop = 1'b0; clear = 1'b0;
    check("all_three_idle", 32'(running), 0);
    do_stop();
    check("stop_in_idle", 32'(running), 0);
    pulses(2);
    check("idle_no_count", 32'(count), 0);

    // Mid-run reset.
    do_start(); pulses(12);
    check("midrst_pre", 32'(count), 12);
    reset_n = 1'b0; cyc(1); reset_n = 1'b1;
    check("midrst_count", 32'(count), 0);
    check("midrst_running", 32'(running), 0);
    pulses(3);
    check("midrst_ignored", 32'(count), 0);
    do_start(); pulses(1);
    check("midrst_restart", 32'(count), 1);

    // Randomized traffic, checked only by the model.
    ph_left = 0;
    for (int i = 0; i < 4000; i++) begin
      if (ph_left == 0) begin
        clock_div = ~clock_div;
        ph_left = $urandom_range(2, 6);
      end
      ph_left--;
      start   = ($urandom_range(0, 7) == 0);
      stop    = ($urandom_range(0, 24) == 0);
      clear   = ($urandom_range(0, 399) == 0);
      reset_n = !($urandom_range(0, 599) == 0);
      cyc(1);
    end
    start = 0; stop = 0; clear = 0; reset_n = 1; cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
